issue_select_age: RTL

- Multi-issue, age-ordered select stage for the out-of-order issue queue; successor to the single-grant tiered ready selector.
- Classifies each entry into readiness tiers A/B/C from operand status, then grants up to ISSUE_WIDTH entries per cycle. Grants are oldest-first, with starvation promotion.
- Grant vector is registered and active-low, and feeds the issue-queue read ports and the busy-marking logic.

---
 rtl/issue_select_age.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/issue_select_age.sv
// issue_select_age: age-ordered multi-issue select stage for the issue queue.
// Ports: clk, reset_ (async, active-low); alloc_/valid/inst_busy/rs1_stat/rs2_stat
// per entry, stall in; issue_vec_ (active-low grants), issue_cnt, starve_alert out.

package issue_select_age_pkg;
  localparam int IqDepth = 16;
  // Status bit that is clear when the operand is ready or will be shortly.
  localparam int RegStatReady_ = 1;
  typedef enum logic [1:0] {
    REG_READY = 2'b00,
    REG_SOON  = 2'b01,
    REG_WAIT  = 2'b10,
    REG_NONE  = 2'b11
  } RegStat_t;
endpackage

module issue_select_age
  import issue_select_age_pkg::*;
#(
  parameter int IQ_DEPTH    = IqDepth,
  parameter int ISSUE_WIDTH = 2,
  parameter int STARVE_TH   = 15,
  parameter int CNT_W       = $clog2(STARVE_TH + 1),
  localparam int ICW        = $clog2(ISSUE_WIDTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset_,
  input  logic [IQ_DEPTH-1:0]      alloc_,
  input  logic [IQ_DEPTH-1:0]      valid,
  input  logic [IQ_DEPTH-1:0]      inst_busy,
  input  RegStat_t [IQ_DEPTH-1:0]  rs1_stat,
  input  RegStat_t [IQ_DEPTH-1:0]  rs2_stat,
  input  logic                     stall,
  output logic [IQ_DEPTH-1:0]      issue_vec_,
  output logic [ICW-1:0]           issue_cnt,
  output logic                     starve_alert
);

  typedef logic [IQ_DEPTH-1:0] vec_t;
  typedef logic [IQ_DEPTH-1:0][IQ_DEPTH-1:0] mat_t;

  mat_t                        old_q, old_d;
  logic [IQ_DEPTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  vec_t                        vec_q, vec_d;
  logic [ICW-1:0]              icnt_q, icnt_d;
  logic                        alert_q, alert_d;

  vec_t tier_a, tier_b, tier_c;
  vec_t sel, sat, starved, pool;
  vec_t gnt, gnt_eff;
  logic [ICW-1:0] n_gnt;

  // Oldest member of set: no other member is older; lowest index breaks
  // ties where the matrix holds no order (e.g. entries never allocated).
  function automatic vec_t oldest(input vec_t set, input mat_t m);
    vec_t res;
    logic found;
    logic ok;
    res   = '0;
    found = 1'b0;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      ok = set[i];
      for (int j = 0; j < IQ_DEPTH; j++) begin
        if (set[j] && m[j][i] && (j != i)) ok = 1'b0;
      end
      if (ok && !found) begin
        res[i] = 1'b1;
        found  = 1'b1;
      end
    end
    return res;
  endfunction

  always_comb begin
    logic [1:0] s1, s2;
    logic r1, r2, m1, m2;
    tier_a = '0;
    tier_b = '0;
    tier_c = '0;
    sel    = '0;
    sat    = '0;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      s1 = rs1_stat[i];
      s2 = rs2_stat[i];
      r1 = (rs1_stat[i] == REG_READY);
      r2 = (rs2_stat[i] == REG_READY);
      m1 = ~s1[RegStatReady_];
      m2 = ~s2[RegStatReady_];
      tier_a[i] = r1 & r2;
      tier_b[i] = ((r1 & m2) | (r2 & m1)) & ~(r1 & r2);
      tier_c[i] = m1 & m2 & ~r1 & ~r2;
      // issue_vec_ term masks last cycle's grant until busy catches up
      sel[i] = valid[i] & ~inst_busy[i] & alloc_[i] & vec_q[i];
      sat[i] = (cnt_q[i] == CNT_W'(STARVE_TH));
    end
  end

  always_comb begin
    vec_t ca, cb, cc, cand;
    ca   = sel & tier_a;
    cb   = sel & tier_b;
    cc   = sel & tier_c;
    cand = (|ca) ? ca : ((|cb) ? cb : cc);
    starved = sel & (tier_a | tier_b) & sat;
    pool    = cand | starved;
  end

  always_comb begin
    vec_t rem_c, rem_s, cls, pick;
    rem_c = pool;
    rem_s = starved;
    gnt   = '0;
    n_gnt = '0;
    for (int s = 0; s < ISSUE_WIDTH; s++) begin
      cls   = (|rem_s) ? rem_s : rem_c;
      pick  = oldest(cls, old_q);
      gnt   = gnt | pick;
      rem_c = rem_c & ~pick;
      rem_s = rem_s & ~pick;
      if (|pick) n_gnt = n_gnt + ICW'(1);
    end
    gnt_eff = stall ? '0 : gnt;
    vec_d   = ~gnt_eff;
    icnt_d  = stall ? '0 : n_gnt;
    alert_d = |(sel & sat);
  end

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      if (!alloc_[i] || gnt_eff[i] || !valid[i]) begin
        cnt_d[i] = '0;
      end else if (stall || inst_busy[i]) begin
        cnt_d[i] = cnt_q[i];
      end else if (sel[i] && (tier_a[i] || tier_b[i]) && !sat[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // A new entry is younger than every resident valid entry; among
  // same-cycle allocs the lower index is older.
  always_comb begin
    old_d = old_q;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      for (int j = 0; j < IQ_DEPTH; j++) begin
        if (i == j) begin
          old_d[i][j] = 1'b0;
        end else if (!alloc_[i]) begin
          old_d[i][j] = !alloc_[j] && (i < j);
        end else if (!alloc_[j]) begin
          old_d[i][j] = valid[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      old_q   <= '0;
      cnt_q   <= '0;
      vec_q   <= '1;
      icnt_q  <= '0;
      alert_q <= 1'b0;
    end else begin
      old_q   <= old_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      icnt_q  <= icnt_d;
      alert_q <= alert_d;
    end
  end

  assign issue_vec_   = vec_q;
  assign issue_cnt    = icnt_q;
  assign starve_alert = alert_q;

endmodule
